// File: rtl/xbus_scheduler_if.sv
// X bus word channel between the pass scheduler and the multicasters.
// Carries one tagged ifmap/filter/psum word per valid/ready handshake.
interface xbus_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_ROW    = 4
);
  localparam int XW = $clog2(NUM_COL);
  localparam int YW = $clog2(NUM_ROW);

  logic                    bus_valid;
  logic                    bus_ready;
  logic [DATA_WIDTH-1:0]   bus_ifmap;
  logic [DATA_WIDTH-1:0]   bus_fltr;
  logic [2*DATA_WIDTH-1:0] bus_psum;
  logic [XW-1:0]           x_tag;
  logic [YW-1:0]           y_tag;

  modport master (
    output bus_valid, bus_ifmap, bus_fltr,
    output bus_psum, x_tag, y_tag,
    input  bus_ready
  );

  modport slave (
    input  bus_valid, bus_ifmap, bus_fltr,
    input  bus_psum, x_tag, y_tag,
    output bus_ready
  );
endinterface

// File: rtl/xbus_scheduler.sv
// X bus pass sequencer: tags source words, drives the bus, flushes casters.
// XBUS_SCHED_FLUSH_TIMEOUT_EN enables the FLUSH_WAIT watchdog.
module xbus_scheduler #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_COL       = 4,
  parameter int NUM_ROW       = 4,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [7:0]              cfg_kernel_size,
  input  logic [15:0]             cfg_num_words,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [DATA_WIDTH-1:0]   src_ifmap,
  input  logic [DATA_WIDTH-1:0]   src_fltr,
  input  logic [2*DATA_WIDTH-1:0] src_psum,
  xbus_scheduler_if.master        bus,
  output logic                    flush,
  input  logic                    flush_busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic                    busy
);
  localparam int XW = $clog2(NUM_COL);
  localparam int YW = $clog2(NUM_ROW);
  localparam logic [XW-1:0] X_LAST = XW'(NUM_COL - 1);
  localparam logic [7:0]    K_MAX  = 8'(NUM_ROW);

  typedef enum logic [2:0] {
    IDLE, STREAM, DRAIN, FLUSH, FLUSH_WAIT, DONE
  } state_t;

  state_t                  state;
  logic                    bus_valid;
  logic [DATA_WIDTH-1:0]   ifmap_q;
  logic [DATA_WIDTH-1:0]   fltr_q;
  logic [2*DATA_WIDTH-1:0] psum_q;
  logic [XW-1:0]           x_tag_q;
  logic [YW-1:0]           y_tag_q;
  logic [15:0]             word_cnt;
  logic [XW-1:0]           x_cnt;
  logic [YW-1:0]           y_cnt;
  logic [15:0]             w_last;
  logic [YW-1:0]           y_last;
  logic                    first_wait;
  logic [7:0]              k_clamp;
  logic                    src_acc;
  logic                    wrap_w;
  logic                    wrap_x;
  logic                    last_word;

`ifdef XBUS_SCHED_FLUSH_TIMEOUT_EN
  localparam int WD_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(FLUSH_TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign k_clamp   = (cfg_kernel_size > K_MAX) ? K_MAX : cfg_kernel_size;
  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign src_ready = (state == STREAM) && (!bus_valid || bus.bus_ready);
  assign src_acc   = src_valid && src_ready;
  assign wrap_w    = (word_cnt == w_last);
  assign wrap_x    = (x_cnt == X_LAST);
  assign last_word = wrap_w && wrap_x && (y_cnt == y_last);

  assign bus.bus_valid = bus_valid;
  assign bus.bus_ifmap = ifmap_q;
  assign bus.bus_fltr  = fltr_q;
  assign bus.bus_psum  = psum_q;
  assign bus.x_tag     = x_tag_q;
  assign bus.y_tag     = y_tag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus_valid  <= 1'b0;
      ifmap_q    <= '0;
      fltr_q     <= '0;
      psum_q     <= '0;
      x_tag_q    <= '0;
      y_tag_q    <= '0;
      word_cnt   <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      w_last     <= '0;
      y_last     <= '0;
      first_wait <= 1'b0;
      flush      <= 1'b0;
      done       <= 1'b0;
`ifdef XBUS_SCHED_FLUSH_TIMEOUT_EN
      wd_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      flush <= 1'b0;
      done  <= 1'b0;
      // Accept wins over completion so back-to-back words keep 1/cycle.
      if (src_acc) begin
        bus_valid <= 1'b1;
        ifmap_q   <= src_ifmap;
        fltr_q    <= src_fltr;
        psum_q    <= src_psum;
        x_tag_q   <= x_cnt;
        y_tag_q   <= y_cnt;
      end else if (bus_valid && bus.bus_ready) begin
        bus_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            w_last   <= cfg_num_words - 16'd1;
            y_last   <= YW'(k_clamp - 8'd1);
            word_cnt <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            if (k_clamp == 8'd0 || cfg_num_words == 16'd0) begin
              state <= FLUSH;
              flush <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (src_acc) begin
            if (wrap_w) begin
              word_cnt <= '0;
              if (wrap_x) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + YW'(1);
              end else begin
                x_cnt <= x_cnt + XW'(1);
              end
            end else begin
              word_cnt <= word_cnt + 16'd1;
            end
            if (last_word) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus_valid || bus.bus_ready) begin
            state <= FLUSH;
            flush <= 1'b1;
          end
        end
        FLUSH: begin
          state      <= FLUSH_WAIT;
          first_wait <= 1'b1;
`ifdef XBUS_SCHED_FLUSH_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
        end
        FLUSH_WAIT: begin
          first_wait <= 1'b0;
`ifdef XBUS_SCHED_FLUSH_TIMEOUT_EN
          wd_cnt <= wd_cnt + WD_W'(1);
          if (!first_wait && !flush_busy) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (flush_busy && wd_cnt == WD_LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            timeout_q <= 1'b1;
          end
`else
          if (!first_wait && !flush_busy) begin
            state <= DONE;
            done  <= 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
`ifdef XBUS_SCHED_FLUSH_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xbus_scheduler.sv
// Directed bench for xbus_scheduler: streaming, backpressure, clamp,
// empty pass, mid-pass reset and flush watchdog behaviour.
module tb_xbus_scheduler;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int NR = 4;
  localparam int FT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [7:0]    cfg_kernel_size;
  logic [15:0]   cfg_num_words;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] src_ifmap;
  logic [DW-1:0] src_fltr;
  logic [2*DW-1:0] src_psum;
  logic          flush;
  logic          flush_busy;
  logic          done;
  logic          timeout_err;
  logic          busy;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  xbus_scheduler_if #(
    .DATA_WIDTH(DW), .NUM_COL(NC), .NUM_ROW(NR)
  ) bus ();

  xbus_scheduler #(
    .DATA_WIDTH(DW), .NUM_COL(NC),
    .NUM_ROW(NR), .FLUSH_TIMEOUT(FT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_kernel_size(cfg_kernel_size),
    .cfg_num_words(cfg_num_words),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_ifmap(src_ifmap),
    .src_fltr(src_fltr),
    .src_psum(src_psum),
    .bus(bus),
    .flush(flush),
    .flush_busy(flush_busy),
    .done(done),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, 64'(obs), 64'(exp));
  endtask

  task automatic drive_word(input int i);
    src_ifmap = 16'h1000 + 16'(i);
    src_fltr  = 16'h2000 + 16'(i);
    src_psum  = 32'hA500_0000 + 32'(i);
  endtask

  task automatic check_word(input string tag, input int i, input int w);
    int x;
    int y;
    x = (i / w) % NC;
    y = i / (w * NC);
    chkb({tag, "_valid"}, bus.bus_valid, 1'b1);
    chk({tag, "_ifmap"}, 64'(bus.bus_ifmap), 64'(16'h1000 + 16'(i)));
    chk({tag, "_fltr"}, 64'(bus.bus_fltr), 64'(16'h2000 + 16'(i)));
    chk({tag, "_psum"}, 64'(bus.bus_psum), 64'(32'hA500_0000 + 32'(i)));
    chk({tag, "_xtag"}, 64'(bus.x_tag), 64'(x));
    chk({tag, "_ytag"}, 64'(bus.y_tag), 64'(y));
  endtask

  task automatic run_stream(input logic [7:0] k, input logic [15:0] w,
                            input int n, input string tag);
    bus.bus_ready   = 1'b1;
    src_valid       = 1'b0;
    cfg_valid       = 1'b1;
    cfg_kernel_size = k;
    cfg_num_words   = w;
    tick();
    cfg_valid = 1'b0;
    chkb({tag, "_cfg_busy"}, busy, 1'b1);
    chkb({tag, "_cfg_ready"}, cfg_ready, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive_word(i);
      src_valid = 1'b1;
      #1;
      chkb({tag, "_src_ready"}, src_ready, 1'b1);
      tick();
      check_word(tag, i, int'(w));
    end
    src_valid = 1'b0;
    tick();
    chkb({tag, "_flush"}, flush, 1'b1);
    chkb({tag, "_bus_idle"}, bus.bus_valid, 1'b0);
    tick();
    chkb({tag, "_flush_pulse"}, flush, 1'b0);
    chkb({tag, "_guard"}, done, 1'b0);
    tick();
    chkb({tag, "_wait"}, done, 1'b0);
    tick();
    chkb({tag, "_done"}, done, 1'b1);
    chkb({tag, "_no_tmo"}, timeout_err, 1'b0);
    tick();
    chkb({tag, "_done_pulse"}, done, 1'b0);
    chkb({tag, "_idle"}, cfg_ready, 1'b1);
  endtask

  initial begin
    int j;
    int got;
    int cyc;
    logic stall;
    logic [DW-1:0]   sv_ifmap;
    logic [2*DW-1:0] sv_psum;
    logic [1:0]      sv_x;

    rst_n           = 1'b0;
    cfg_valid       = 1'b0;
    cfg_kernel_size = 8'd0;
    cfg_num_words   = 16'd0;
    src_valid       = 1'b0;
    src_ifmap       = '0;
    src_fltr        = '0;
    src_psum        = '0;
    bus.bus_ready   = 1'b0;
    flush_busy      = 1'b0;
    tick();
    tick();
    chkb("rst_cfg_ready", cfg_ready, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_bus_valid", bus.bus_valid, 1'b0);
    chkb("rst_flush", flush, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_tmo", timeout_err, 1'b0);
    chkb("rst_src_ready", src_ready, 1'b0);
    chk("rst_xtag", 64'(bus.x_tag), 64'd0);
    chk("rst_ytag", 64'(bus.y_tag), 64'd0);
    chk("rst_ifmap", 64'(bus.bus_ifmap), 64'd0);
    chk("rst_psum", 64'(bus.bus_psum), 64'd0);
    rst_n = 1'b1;
    tick();

    run_stream(8'd2, 16'd3, 24, "k2w3");
    run_stream(8'd9, 16'd1, 16, "clamp");

    // Backpressure: bus_ready alternates 1,0,1,0 over an 8-word pass.
    cfg_valid       = 1'b1;
    cfg_kernel_size = 8'd1;
    cfg_num_words   = 16'd2;
    tick();
    cfg_valid = 1'b0;
    j   = 0;
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 100) begin
      bus.bus_ready = (cyc % 2 == 0);
      src_valid     = (j < 8);
      drive_word(j);
      #1;
      if (bus.bus_valid && bus.bus_ready) begin
        check_word("bp", got, 2);
        got++;
      end
      stall    = bus.bus_valid && !bus.bus_ready;
      sv_ifmap = bus.bus_ifmap;
      sv_psum  = bus.bus_psum;
      sv_x     = bus.x_tag;
      if (src_valid && src_ready) j++;
      tick();
      cyc++;
      if (stall) begin
        chkb("bp_hold_valid", bus.bus_valid, 1'b1);
        chk("bp_hold_ifmap", 64'(bus.bus_ifmap), 64'(sv_ifmap));
        chk("bp_hold_psum", 64'(bus.bus_psum), 64'(sv_psum));
        chk("bp_hold_xtag", 64'(bus.x_tag), 64'(sv_x));
      end
    end
    chk("bp_count", 64'(got), 64'd8);
    chk("bp_src_count", 64'(j), 64'd8);
    src_valid     = 1'b0;
    bus.bus_ready = 1'b1;
    for (int c = 0; c < 10 && !done; c++) tick();
    chkb("bp_done", done, 1'b1);
    tick();

    // Empty pass: W=0 must never request source words.
    cfg_valid       = 1'b1;
    cfg_kernel_size = 8'd2;
    cfg_num_words   = 16'd0;
    src_valid       = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chkb("empty_flush", flush, 1'b1);
    chkb("empty_src_ready0", src_ready, 1'b0);
    tick();
    chkb("empty_flush_pulse", flush, 1'b0);
    chkb("empty_src_ready1", src_ready, 1'b0);
    chkb("empty_guard", done, 1'b0);
    tick();
    chkb("empty_wait", done, 1'b0);
    tick();
    chkb("empty_done", done, 1'b1);
    chkb("empty_bus_idle", bus.bus_valid, 1'b0);
    tick();
    chkb("empty_idle", cfg_ready, 1'b1);
    src_valid = 1'b0;

    // Reset in the middle of a stream, then a clean pass.
    cfg_valid       = 1'b1;
    cfg_kernel_size = 8'd1;
    cfg_num_words   = 16'd4;
    tick();
    cfg_valid = 1'b0;
    src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_word(100 + i);
      tick();
    end
    chkb("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    src_valid = 1'b0;
    chkb("mid_rst_bus_valid", bus.bus_valid, 1'b0);
    chkb("mid_rst_flush", flush, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_cfg_ready", cfg_ready, 1'b1);
    chkb("mid_rst_src_ready", src_ready, 1'b0);
    run_stream(8'd1, 16'd4, 16, "after_rst");

    // Multicasters never finish draining.
    flush_busy      = 1'b1;
    cfg_valid       = 1'b1;
    cfg_kernel_size = 8'd2;
    cfg_num_words   = 16'd0;
    tick();
    cfg_valid = 1'b0;
    chkb("stuck_flush", flush, 1'b1);
    tick();
`ifdef XBUS_SCHED_FLUSH_TIMEOUT_EN
    for (int c = 1; c <= FT; c++) begin
      tick();
      if (c < FT) begin
        chkb("tmo_early_done", done, 1'b0);
        chkb("tmo_early_err", timeout_err, 1'b0);
      end else begin
        chkb("tmo_done", done, 1'b1);
        chkb("tmo_err", timeout_err, 1'b1);
      end
    end
    flush_busy = 1'b0;
    tick();
    chkb("tmo_done_pulse", done, 1'b0);
    chkb("tmo_err_clear", timeout_err, 1'b0);
    chkb("tmo_idle", cfg_ready, 1'b1);
`else
    for (int c = 1; c <= 40; c++) begin
      tick();
      chkb("stuck_no_done", done, 1'b0);
      chkb("stuck_no_err", timeout_err, 1'b0);
    end
    chkb("stuck_busy", busy, 1'b1);
    flush_busy = 1'b0;
    tick();
    chkb("stuck_release_done", done, 1'b1);
    tick();
    chkb("stuck_release_idle", cfg_ready, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
